// File: rtl/usb_rx_rcu.sv
// ---------------------------------------------------------------------------
// usb_rx_rcu -- USB receiver control unit.
//
// Sequences one packet: waits for the first bus transition, checks the sync
// byte, hands each following data byte to the RX FIFO with a one-cycle write
// strobe, and classifies the end of packet as good (EOP on a byte boundary)
// or bad (bad sync, EOP mid-byte, or more than MAX_BYTES data bytes).
//
// Ports
//   clk            in   system clock, rising edge
//   rst            in   asynchronous active-high reset
//   d_edge         in   pulse: bus transition detected
//   eop            in   SE0 level, only meaningful together with shift_enable
//   shift_enable   in   pulse: one per bit period
//   byte_received  in   pulse: rcv_data holds a complete byte
//   rcv_data[7:0]  in   most recently assembled byte
//   rcving         out  packet reception in progress (registered)
//   w_enable       out  FIFO write strobe for rcv_data (registered)
//   r_error        out  sticky receive error, cleared by the next packet start
//   byte_cnt[7:0]  out  data bytes written in the current packet
//   state_dbg[2:0] out  current FSM state, for observation only
//
// Handshake: there is no back-pressure. Every input pulse is consumed in the
// cycle it is sampled; w_enable is a fire-and-forget strobe that is high for
// exactly one cycle per stored byte, with rcv_data still holding that byte.
// ---------------------------------------------------------------------------
module usb_rx_rcu #(
    parameter logic [7:0]  SYNC_BYTE = 8'h80,
    parameter int unsigned MAX_BYTES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       d_edge,
    input  logic       eop,
    input  logic       shift_enable,
    input  logic       byte_received,
    input  logic [7:0] rcv_data,
    output logic       rcving,
    output logic       w_enable,
    output logic       r_error,
    output logic [7:0] byte_cnt,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RCV_SYNC = 3'd1,
        CHK_SYNC = 3'd2,
        RCV_DATA = 3'd3,
        STORE    = 3'd4,
        EOP_WAIT = 3'd5,
        ERR_WAIT = 3'd6,
        ERR_EOP  = 3'd7
    } state_t;

    localparam logic [7:0] MAX_CNT = 8'(MAX_BYTES);

    state_t     state;
    state_t     next_state;
    logic [2:0] bit_cnt;
    logic [2:0] next_bit_cnt;
    logic [7:0] next_byte_cnt;
    logic       next_w_enable;
    logic       next_r_error;
    logic       next_rcving;
    logic       eop_bit;

    // An EOP only counts when it is sampled on a bit period.
    assign eop_bit   = eop & shift_enable;
    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rcving   <= 1'b0;
            w_enable <= 1'b0;
            r_error  <= 1'b0;
            byte_cnt <= 8'd0;
            bit_cnt  <= 3'd0;
        end else begin
            state    <= next_state;
            rcving   <= next_rcving;
            w_enable <= next_w_enable;
            r_error  <= next_r_error;
            byte_cnt <= next_byte_cnt;
            bit_cnt  <= next_bit_cnt;
        end
    end

    always_comb begin
        next_state    = state;
        next_w_enable = 1'b0;
        next_r_error  = r_error;
        next_byte_cnt = byte_cnt;
        next_bit_cnt  = bit_cnt;

        case (state)
            IDLE: begin
                // A new packet wipes the previous packet's status.
                if (d_edge) begin
                    next_state    = RCV_SYNC;
                    next_r_error  = 1'b0;
                    next_byte_cnt = 8'd0;
                    next_bit_cnt  = 3'd0;
                end
            end

            RCV_SYNC: begin
                if (eop_bit) begin
                    next_state   = ERR_EOP;
                    next_r_error = 1'b1;
                end else if (byte_received) begin
                    next_state = CHK_SYNC;
                end
            end

            CHK_SYNC: begin
                // rcv_data still holds the byte that arrived last cycle.
                if (rcv_data == SYNC_BYTE) begin
                    next_state = RCV_DATA;
                end else begin
                    next_state   = ERR_WAIT;
                    next_r_error = 1'b1;
                end
            end

            RCV_DATA: begin
                // EOP wins over a coincident byte: that byte is dropped.
                if (eop_bit) begin
                    if (bit_cnt == 3'd0) begin
                        next_state = EOP_WAIT;
                    end else begin
                        next_state   = ERR_EOP;
                        next_r_error = 1'b1;
                    end
                end else if (byte_received) begin
                    next_state   = STORE;
                    next_bit_cnt = 3'd0;
                end else if (shift_enable) begin
                    next_bit_cnt = bit_cnt + 3'd1;
                end
            end

            STORE: begin
                // Saturate at MAX_BYTES: an extra byte is an error, not a wrap.
                if (byte_cnt < MAX_CNT) begin
                    next_state    = RCV_DATA;
                    next_w_enable = 1'b1;
                    next_byte_cnt = byte_cnt + 8'd1;
                end else begin
                    next_state   = ERR_WAIT;
                    next_r_error = 1'b1;
                end
            end

            ERR_WAIT: begin
                // Swallow the rest of a bad packet until its EOP.
                if (eop_bit) begin
                    next_state = ERR_EOP;
                end
            end

            EOP_WAIT, ERR_EOP: begin
                // Wait for the bus to return to idle J before rearming.
                if (d_edge) begin
                    next_state = IDLE;
                end
            end

            default: begin
                next_state = IDLE;
            end
        endcase

        next_rcving = (next_state != IDLE);
    end

endmodule

// File: tb/tb_usb_rx_rcu.sv
// ---------------------------------------------------------------------------
// tb_usb_rx_rcu -- self-checking bench for usb_rx_rcu (MAX_BYTES = 2).
//
// Packets are described by a sync byte, a list of data bytes and an ending
// kind; a packet-level model predicts the FIFO writes and final status.
// Predicted writes go into exp_q; a monitor on the falling edge pops one
// entry per w_enable and compares data and byte count.
// ---------------------------------------------------------------------------
module tb_usb_rx_rcu;

    localparam logic [7:0] SYNC  = 8'h80;
    localparam int         MAX_B = 2;
    localparam int         W     = 16;

    // ending kinds
    localparam int END_GOOD  = 0;  // EOP on a byte boundary
    localparam int END_EARLY = 1;  // EOP after k stray bits
    localparam int END_COINC = 2;  // last byte arrives together with EOP
    localparam int END_SYNC  = 3;  // EOP while still waiting for sync

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       d_edge = 1'b0;
    logic       eop = 1'b0;
    logic       shift_enable = 1'b0;
    logic       byte_received = 1'b0;
    logic [7:0] rcv_data = 8'h00;
    logic       rcving;
    logic       w_enable;
    logic       r_error;
    logic [7:0] byte_cnt;
    logic [2:0] state_dbg;

    always #5 clk = ~clk;

    usb_rx_rcu #(
        .SYNC_BYTE(SYNC),
        .MAX_BYTES(MAX_B)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .d_edge       (d_edge),
        .eop          (eop),
        .shift_enable (shift_enable),
        .byte_received(byte_received),
        .rcv_data     (rcv_data),
        .rcving       (rcving),
        .w_enable     (w_enable),
        .r_error      (r_error),
        .byte_cnt     (byte_cnt),
        .state_dbg    (state_dbg)
    );

    int         checks = 0;
    int         errors = 0;
    logic [W-1:0] exp_q[$];
    logic [7:0] pkt_q[$];
    logic       prev_we = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (w_enable) begin
                if (prev_we) begin
                    checks++;
                    errors++;
                    $display("FAIL w_enable_width: strobe high two cycles in a row at %0t", $time);
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got data %0h cnt %0d expected no write at %0t",
                             rcv_data, byte_cnt, $time);
                end else begin
                    check("write", 32'({byte_cnt, rcv_data}), 32'(exp_q.pop_front()));
                end
            end
            prev_we <= w_enable;
        end else begin
            prev_we <= 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_edge();
        d_edge = 1'b1;
        tick();
        d_edge = 1'b0;
    endtask

    task automatic send_shift(input logic e);
        shift_enable = 1'b1;
        eop = e;
        tick();
        shift_enable = 1'b0;
        eop = 1'b0;
        tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_shift(1'b0);
        rcv_data = b;
        byte_received = 1'b1;
        tick();
        byte_received = 1'b0;
        idle(2);
    endtask

    // Drives one packet from pkt_q and checks it against the packet model.
    task automatic run_packet(input logic [7:0] sync, input int kind, input int k);
        int n;
        int nst;
        int exp_cnt;
        logic exp_err;

        n = pkt_q.size();
        // model: which bytes reach the FIFO and how the packet ends
        if (kind == END_SYNC || sync != SYNC) begin
            exp_err = 1'b1;
            exp_cnt = 0;
        end else begin
            nst = (kind == END_COINC) ? n - 1 : n;
            exp_cnt = (nst < MAX_B) ? nst : MAX_B;
            for (int i = 0; i < exp_cnt; i++) exp_q.push_back({8'(i + 1), pkt_q[i]});
            exp_err = (nst > MAX_B) || (kind == END_EARLY);
        end

        send_edge();
        check("rcving_start", 32'(rcving), 32'd1);

        if (kind == END_SYNC) begin
            for (int i = 0; i < k; i++) send_shift(1'b0);
            send_shift(1'b1);
        end else begin
            send_byte(sync);
            for (int i = 0; i < ((kind == END_COINC) ? n - 1 : n); i++) send_byte(pkt_q[i]);
            if (kind == END_COINC) begin
                for (int i = 0; i < 8; i++) send_shift(1'b0);
                rcv_data = pkt_q[n - 1];
                byte_received = 1'b1;
                shift_enable = 1'b1;
                eop = 1'b1;
                tick();
                byte_received = 1'b0;
                shift_enable = 1'b0;
                eop = 1'b0;
                tick();
            end else begin
                if (kind == END_EARLY) begin
                    for (int i = 0; i < k; i++) send_shift(1'b0);
                end
                send_shift(1'b1);
            end
        end

        idle(3);
        check("writes_drained", 32'(exp_q.size()), 32'd0);
        check("rcving_at_eop", 32'(rcving), 32'd1);
        check("r_error_at_eop", 32'(r_error), 32'(exp_err));

        send_edge();
        idle(1);
        check("rcving_idle", 32'(rcving), 32'd0);
        check("r_error_end", 32'(r_error), 32'(exp_err));
        check("byte_cnt_end", 32'(byte_cnt), 32'(exp_cnt));
        idle(3);
        check("r_error_sticky", 32'(r_error), 32'(exp_err));
        exp_q.delete();
        pkt_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int kind;
        int n;
        int k;
        logic [7:0] s;

        // reset
        rst = 1'b1;
        idle(2);
        check("rst_rcving", 32'(rcving), 32'd0);
        check("rst_w_enable", 32'(w_enable), 32'd0);
        check("rst_r_error", 32'(r_error), 32'd0);
        check("rst_byte_cnt", 32'(byte_cnt), 32'd0);
        rst = 1'b0;
        idle(2);

        // good packet
        pkt_q = '{8'hA5, 8'h3C};
        run_packet(SYNC, END_GOOD, 0);

        // bad sync
        pkt_q = '{8'h11, 8'h22};
        run_packet(8'h81, END_GOOD, 0);

        // early EOP after 3 bits
        pkt_q = '{8'h5A};
        run_packet(SYNC, END_EARLY, 3);

        // overflow: 3 bytes with room for 2
        pkt_q = '{8'h01, 8'h02, 8'h03};
        run_packet(SYNC, END_GOOD, 0);

        // byte coincident with EOP is dropped, packet still good
        pkt_q = '{8'hC3, 8'h99};
        run_packet(SYNC, END_COINC, 0);

        // EOP before the sync byte
        run_packet(SYNC, END_SYNC, 2);

        // reset mid-packet, then a clean 1-byte packet
        send_edge();
        send_byte(SYNC);
        exp_q.push_back({8'd1, 8'h77});
        send_byte(8'h77);
        idle(2);
        check("pre_rst_byte_cnt", 32'(byte_cnt), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_rcving", 32'(rcving), 32'd0);
        check("mid_rst_byte_cnt", 32'(byte_cnt), 32'd0);
        check("mid_rst_w_enable", 32'(w_enable), 32'd0);
        check("mid_rst_r_error", 32'(r_error), 32'd0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        idle(2);
        pkt_q = '{8'h4E};
        run_packet(SYNC, END_GOOD, 0);

        // randomized packets
        for (int p = 0; p < 40; p++) begin
            kind = $urandom_range(0, 3);
            n = $urandom_range(0, 4);
            if (kind == END_COINC && n == 0) n = 1;
            for (int i = 0; i < n; i++) pkt_q.push_back(8'($urandom_range(0, 255)));
            s = SYNC;
            if ($urandom_range(0, 3) == 0) begin
                s = 8'($urandom_range(0, 255));
                if (s == SYNC) s = SYNC ^ 8'h01;
            end
            k = (kind == END_EARLY) ? $urandom_range(1, 7) : $urandom_range(0, 3);
            run_packet(s, kind, k);
        end

        idle(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/usb_rx_rcu.md
USB_RX_RCU -- requirements
Module: usb_rx_rcu

Interface
REQ-001 Parameter SYNC_BYTE, default 8'h80: expected sync pattern as presented on rcv_data.
REQ-002 Parameter MAX_BYTES, default 64: maximum data bytes per packet (sync excluded), range 1..255.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 d_edge  input  1  single-cycle pulse, bus transition detected (from edge detector).
REQ-006 eop  input  1  end-of-packet (SE0) level, sampled only when shift_enable=1.
REQ-007 shift_enable  input  1  single-cycle pulse, one per bit period.
REQ-008 byte_received  input  1  single-cycle pulse, rcv_data holds a complete byte.
REQ-009 rcv_data  input  8  most recently assembled byte.
REQ-010 rcving  output  1  packet reception in progress.
REQ-011 w_enable  output  1  single-cycle FIFO write strobe for rcv_data.
REQ-012 r_error  output  1  sticky receive-error flag.
REQ-013 byte_cnt  output  8  data bytes written in current packet.

Function
REQ-014 States SHALL be: IDLE, RCV_SYNC, CHK_SYNC, RCV_DATA, STORE, EOP_WAIT, ERR_WAIT, ERR_EOP.
REQ-015 Outputs rcving and w_enable SHALL be registered (flops), valid one cycle after the triggering input; no combinational input-to-output path.
REQ-016 IDLE: d_edge -> RCV_SYNC; same edge clears r_error, byte_cnt, bit_cnt.
REQ-017 RCV_SYNC: byte_received -> CHK_SYNC; eop&shift_enable -> ERR_EOP with r_error set.
REQ-018 CHK_SYNC (exactly one cycle): rcv_data==SYNC_BYTE -> RCV_DATA; else -> ERR_WAIT with r_error set.
REQ-019 RCV_DATA: internal 3-bit bit_cnt SHALL increment on each shift_enable, wrap 7->0, and clear on byte_received.
REQ-020 RCV_DATA: eop&shift_enable with bit_cnt==0 -> EOP_WAIT (good packet); with bit_cnt!=0 -> ERR_EOP with r_error set.
REQ-021 RCV_DATA: byte_received (no eop) -> STORE.
REQ-022 Simultaneous eop&shift_enable and byte_received in RCV_DATA: eop branch SHALL take priority; byte not stored.
REQ-023 STORE (one cycle): if byte_cnt<MAX_BYTES, w_enable=1 on next cycle, byte_cnt+1, -> RCV_DATA; else no write, r_error set, -> ERR_WAIT.
REQ-024 byte_cnt SHALL never exceed MAX_BYTES; no wrap.
REQ-025 ERR_WAIT: eop&shift_enable -> ERR_EOP; all byte_received ignored, w_enable=0.
REQ-026 EOP_WAIT and ERR_EOP: d_edge (return to idle J) -> IDLE.
REQ-027 rcving=1 in every state except IDLE.
REQ-028 r_error SHALL remain set through IDLE until next packet's d_edge (REQ-016).
REQ-029 w_enable SHALL never assert for the sync byte or for more than one cycle per byte.
REQ-030 Unreachable state encodings SHALL recover to IDLE on next clock.

Reset
REQ-031 rst=1 SHALL asynchronously force IDLE, rcving=0, w_enable=0, r_error=0, byte_cnt=0, bit_cnt=0, including mid-packet.
REQ-032 After rst deasserts, first d_edge SHALL start reception normally; no partial-packet state retained.

Verification
REQ-033 Good packet: d_edge, sync 8'h80, bytes 8'hA5, 8'h3C, EOP at bit boundary, d_edge -> two w_enable pulses with rcv_data A5 then 3C, byte_cnt=2, r_error=0, rcving 1->0.
REQ-034 Bad sync: first byte 8'h81 -> r_error=1, no w_enable through EOP, IDLE after closing d_edge, r_error still 1.
REQ-035 Early EOP: sync, one byte, then EOP after 3 shift_enable pulses -> one w_enable, r_error=1, IDLE after d_edge.
REQ-036 Overflow with MAX_BYTES=2: sync plus 3 data bytes -> exactly 2 w_enable, byte_cnt=2, r_error=1, third byte dropped.
REQ-037 Reset mid-packet: assert rst after 1 data byte, release, send good 1-byte packet -> r_error=0, byte_cnt=1, one w_enable.
REQ-038 Priority: byte_received coincident with eop&shift_enable in RCV_DATA -> no w_enable that byte, EOP path taken per REQ-020.
